// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the two-client memory arbiter: FSM state encoding,
// opcode values and default bus widths.
package mem_arbiter_pkg;

    localparam int unsigned DEF_LEN_BITS  = 8;
    localparam int unsigned DEF_ADDR_BITS = 64;
    localparam int unsigned DEF_DATA_BITS = 64;

    localparam logic OP_READ  = 1'b0;
    localparam logic OP_WRITE = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_RD,
        ST_WR
    } state_t;

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-way round-robin arbiter: combinational grant from the current requests,
// pointer remembers the last winner and advances on every accepted grant.
module rr_arb2 (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       grant_en,
    output logic [1:0] grant,
    output logic       grant_idx
);

    // Holds the last granted client; reset to 1 so client 0 wins the first tie.
    logic last;

    always_comb begin
        if (req == 2'b11) begin
            grant_idx = ~last;
        end else begin
            grant_idx = req[1];
        end
        grant = {grant_idx, ~grant_idx} & {2{|req}};
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            last <= 1'b1;
        end else if (grant_en && (|req)) begin
            last <= grant_idx;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates two clients onto one burst memory port; one transaction owns the
// port from grant until its last beat.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned MEM_LEN_BITS  = DEF_LEN_BITS,
    parameter int unsigned MEM_ADDR_BITS = DEF_ADDR_BITS,
    parameter int unsigned MEM_DATA_BITS = DEF_DATA_BITS
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [1:0]                 cl_req_valid,
    output logic [1:0]                 cl_req_ready,
    input  logic [1:0]                 cl_req_opcode,
    input  logic [2*MEM_LEN_BITS-1:0]  cl_req_len,
    input  logic [2*MEM_ADDR_BITS-1:0] cl_req_addr,
    input  logic [1:0]                 cl_wr_valid,
    input  logic [2*MEM_DATA_BITS-1:0] cl_wr_bits,
    output logic [1:0]                 cl_rd_valid,
    output logic [MEM_DATA_BITS-1:0]   cl_rd_bits,
    input  logic [1:0]                 cl_rd_ready,
    output logic                       mem_req_valid,
    output logic                       mem_req_opcode,
    output logic [MEM_LEN_BITS-1:0]    mem_req_len,
    output logic [MEM_ADDR_BITS-1:0]   mem_req_addr,
    output logic                       mem_wr_valid,
    output logic [MEM_DATA_BITS-1:0]   mem_wr_bits,
    input  logic                       mem_rd_valid,
    input  logic [MEM_DATA_BITS-1:0]   mem_rd_bits,
    output logic                       mem_rd_ready
);

    localparam logic [MEM_LEN_BITS-1:0] CNT_ONE = MEM_LEN_BITS'(1);

    state_t                    state;
    logic                      owner;
    logic [MEM_LEN_BITS-1:0]   cnt;
    logic [1:0]                grant;
    logic                      grant_idx;
    logic                      beat;
    logic [MEM_LEN_BITS-1:0]   sel_len;
    logic [MEM_ADDR_BITS-1:0]  sel_addr;

    rr_arb2 u_rr (
        .clock     (clock),
        .reset     (reset),
        .req       (cl_req_valid),
        .grant_en  (state == ST_IDLE),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign sel_len  = grant_idx ? cl_req_len[2*MEM_LEN_BITS-1:MEM_LEN_BITS]
                                : cl_req_len[MEM_LEN_BITS-1:0];
    assign sel_addr = grant_idx ? cl_req_addr[2*MEM_ADDR_BITS-1:MEM_ADDR_BITS]
                                : cl_req_addr[MEM_ADDR_BITS-1:0];

    // Data-phase paths are combinational so a beat handshake costs no extra cycle.
    always_comb begin
        cl_rd_valid  = '0;
        mem_rd_ready = 1'b0;
        mem_wr_valid = 1'b0;
        mem_wr_bits  = '0;
        cl_rd_bits   = mem_rd_bits;
        if (state == ST_RD) begin
            mem_rd_ready       = cl_rd_ready[owner];
            cl_rd_valid[owner] = mem_rd_valid;
        end
        if (state == ST_WR) begin
            mem_wr_valid = cl_wr_valid[owner];
            mem_wr_bits  = owner ? cl_wr_bits[2*MEM_DATA_BITS-1:MEM_DATA_BITS]
                                 : cl_wr_bits[MEM_DATA_BITS-1:0];
        end
        beat = (state == ST_RD) ? (mem_rd_valid & mem_rd_ready)
                                : mem_wr_valid;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state          <= ST_IDLE;
            owner          <= 1'b0;
            cnt            <= '0;
            mem_req_valid  <= 1'b0;
            mem_req_opcode <= 1'b0;
            mem_req_len    <= '0;
            mem_req_addr   <= '0;
            cl_req_ready   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (|cl_req_valid) begin
                        owner          <= grant_idx;
                        mem_req_opcode <= cl_req_opcode[grant_idx];
                        mem_req_len    <= sel_len;
                        mem_req_addr   <= sel_addr;
                        cnt            <= sel_len;
                        mem_req_valid  <= 1'b1;
                        cl_req_ready   <= grant;
                        state          <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    mem_req_valid <= 1'b0;
                    cl_req_ready  <= '0;
                    state         <= (mem_req_opcode == OP_WRITE) ? ST_WR : ST_RD;
                end
                ST_RD, ST_WR: begin
                    // Counter stops at zero on the last beat, so len=all-ones never wraps.
                    if (beat) begin
                        if (cnt == '0) begin
                            state <= ST_IDLE;
                        end else begin
                            cnt <= cnt - CNT_ONE;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a table of single transactions plus
// hand-written sequences for arbitration order, stalls and mid-burst reset.
module tb_mem_arbiter;

    logic         clock;
    logic         reset;
    logic [1:0]   cl_req_valid;
    logic [1:0]   cl_req_ready;
    logic [1:0]   cl_req_opcode;
    logic [15:0]  cl_req_len;
    logic [127:0] cl_req_addr;
    logic [1:0]   cl_wr_valid;
    logic [127:0] cl_wr_bits;
    logic [1:0]   cl_rd_valid;
    logic [63:0]  cl_rd_bits;
    logic [1:0]   cl_rd_ready;
    logic         mem_req_valid;
    logic         mem_req_opcode;
    logic [7:0]   mem_req_len;
    logic [63:0]  mem_req_addr;
    logic         mem_wr_valid;
    logic [63:0]  mem_wr_bits;
    logic         mem_rd_valid;
    logic [63:0]  mem_rd_bits;
    logic         mem_rd_ready;

    int errors = 0;
    int checks = 0;

    mem_arbiter #(
        .MEM_LEN_BITS  (8),
        .MEM_ADDR_BITS (64),
        .MEM_DATA_BITS (64)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .cl_req_valid   (cl_req_valid),
        .cl_req_ready   (cl_req_ready),
        .cl_req_opcode  (cl_req_opcode),
        .cl_req_len     (cl_req_len),
        .cl_req_addr    (cl_req_addr),
        .cl_wr_valid    (cl_wr_valid),
        .cl_wr_bits     (cl_wr_bits),
        .cl_rd_valid    (cl_rd_valid),
        .cl_rd_bits     (cl_rd_bits),
        .cl_rd_ready    (cl_rd_ready),
        .mem_req_valid  (mem_req_valid),
        .mem_req_opcode (mem_req_opcode),
        .mem_req_len    (mem_req_len),
        .mem_req_addr   (mem_req_addr),
        .mem_wr_valid   (mem_wr_valid),
        .mem_wr_bits    (mem_wr_bits),
        .mem_rd_valid   (mem_rd_valid),
        .mem_rd_bits    (mem_rd_bits),
        .mem_rd_ready   (mem_rd_ready)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        int          client;
        logic        op;
        logic [7:0]  len;
        logic [63:0] addr;
        logic [63:0] data0;
        int          exp_beats;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_beats();
        mem_rd_valid = 1'b0;
        mem_rd_bits  = '0;
        cl_rd_ready  = '0;
        cl_wr_valid  = '0;
        cl_wr_bits   = '0;
    endtask

    task automatic set_req(input int c, input logic op, input logic [7:0] len, input logic [63:0] addr);
        cl_req_valid[c]       = 1'b1;
        cl_req_opcode[c]      = op;
        cl_req_len[c*8 +: 8]  = len;
        cl_req_addr[c*64 +: 64] = addr;
    endtask

    task automatic check_grant(input string tag, input int c, input logic op,
                               input logic [7:0] len, input logic [63:0] addr);
        chk({tag, " req_valid"}, {63'd0, mem_req_valid}, 64'd1);
        chk({tag, " req_ready"}, {62'd0, cl_req_ready}, 64'(2'b01 << c));
        chk({tag, " req_opcode"}, {63'd0, mem_req_opcode}, {63'd0, op});
        chk({tag, " req_len"}, {56'd0, mem_req_len}, {56'd0, len});
        chk({tag, " req_addr"}, mem_req_addr, addr);
    endtask

    task automatic start_req(input string tag, input int c, input logic op,
                             input logic [7:0] len, input logic [63:0] addr);
        @(negedge clock);
        set_req(c, op, len, addr);
        @(negedge clock);
        check_grant(tag, c, op, len, addr);
        cl_req_valid[c] = 1'b0;
    endtask

    // Offers a beat every cycle until the arbiter stops taking them; the
    // cycle in which no beat is taken is the IDLE cycle after the burst.
    task automatic run_beats(input string tag, input int c, input logic op,
                             input logic [63:0] base, input int exp_beats);
        int  n = 0;
        bit  done = 0;
        for (int k = 0; k < 300 && !done; k++) begin
            @(negedge clock);
            if (op) begin
                cl_wr_valid = 2'b11;
                cl_wr_bits[c*64 +: 64]     = base + 64'(n);
                cl_wr_bits[(1-c)*64 +: 64] = 64'hDEAD_0000 + 64'(n);
            end else begin
                mem_rd_valid = 1'b1;
                mem_rd_bits  = base + 64'(n);
                cl_rd_ready  = 2'b11;
            end
            #1;
            if (op ? mem_wr_valid : (mem_rd_valid && mem_rd_ready)) begin
                if (op) begin
                    chk({tag, " wr_bits"}, mem_wr_bits, base + 64'(n));
                end else begin
                    chk({tag, " rd_bits"}, cl_rd_bits, base + 64'(n));
                    chk({tag, " rd_valid"}, {62'd0, cl_rd_valid}, 64'(2'b01 << c));
                end
                n++;
            end else begin
                done = 1;
            end
        end
        chk({tag, " idle rd_valid"}, {62'd0, cl_rd_valid}, 64'd0);
        chk({tag, " beats"}, 64'(n), 64'(exp_beats));
        clear_beats();
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, " req_valid"}, {63'd0, mem_req_valid}, 64'd0);
        chk({tag, " req_ready"}, {62'd0, cl_req_ready}, 64'd0);
        chk({tag, " rd_valid"}, {62'd0, cl_rd_valid}, 64'd0);
        chk({tag, " mem_rd_ready"}, {63'd0, mem_rd_ready}, 64'd0);
        chk({tag, " mem_wr_valid"}, {63'd0, mem_wr_valid}, 64'd0);
        chk({tag, " req_len"}, {56'd0, mem_req_len}, 64'd0);
        chk({tag, " req_addr"}, mem_req_addr, 64'd0);
    endtask

    initial begin
        vecs[0] = '{client: 0, op: 1'b0, len: 8'd3,   addr: 64'h100, data0: 64'h1000, exp_beats: 4};
        vecs[1] = '{client: 1, op: 1'b1, len: 8'd1,   addr: 64'h200, data0: 64'hA,    exp_beats: 2};
        vecs[2] = '{client: 1, op: 1'b0, len: 8'd0,   addr: 64'h300, data0: 64'h3000, exp_beats: 1};
        vecs[3] = '{client: 0, op: 1'b1, len: 8'd2,   addr: 64'h340, data0: 64'h50,   exp_beats: 3};
        vecs[4] = '{client: 0, op: 1'b0, len: 8'hFF,  addr: 64'h800, data0: 64'h9000, exp_beats: 256};

        reset         = 1'b1;
        cl_req_valid  = '0;
        cl_req_opcode = '0;
        cl_req_len    = '0;
        cl_req_addr   = '0;
        clear_beats();
        repeat (3) @(negedge clock);
        mem_rd_valid = 1'b1;
        cl_rd_ready  = 2'b11;
        #1;
        check_all_zero("reset");
        clear_beats();
        @(negedge clock);
        reset = 1'b0;

        // Simultaneous requests: client 0 first, client 1 in the IDLE cycle after.
        @(negedge clock);
        set_req(0, 1'b0, 8'd1, 64'h400);
        set_req(1, 1'b1, 8'd0, 64'h500);
        @(negedge clock);
        check_grant("both c0", 0, 1'b0, 8'd1, 64'h400);
        cl_req_valid[0] = 1'b0;
        run_beats("both c0", 0, 1'b0, 64'h4000, 2);
        @(negedge clock);
        check_grant("both c1", 1, 1'b1, 8'd0, 64'h500);
        cl_req_valid[1] = 1'b0;
        run_beats("both c1", 1, 1'b1, 64'h77, 1);

        foreach (vecs[i]) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            start_req(tag, vecs[i].client, vecs[i].op, vecs[i].len, vecs[i].addr);
            run_beats(tag, vecs[i].client, vecs[i].op, vecs[i].data0, vecs[i].exp_beats);
        end

        // Client not ready: memory beat must be held off and the count untouched.
        start_req("stall", 0, 1'b0, 8'd1, 64'h600);
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            mem_rd_valid = 1'b1;
            mem_rd_bits  = 64'h6000;
            cl_rd_ready  = 2'b00;
            #1;
            chk("stall mem_rd_ready", {63'd0, mem_rd_ready}, 64'd0);
        end
        run_beats("stall", 0, 1'b0, 64'h6000, 2);

        // Reset during the second beat of an 8-beat read.
        start_req("rst", 0, 1'b0, 8'd7, 64'h700);
        @(negedge clock);
        mem_rd_valid = 1'b1;
        mem_rd_bits  = 64'h7000;
        cl_rd_ready  = 2'b01;
        #1;
        chk("rst beat1", {63'd0, mem_rd_ready}, 64'd1);
        @(negedge clock);
        mem_rd_bits = 64'h7001;
        #1;
        reset = 1'b1;
        #1;
        chk("rst async rd_ready", {63'd0, mem_rd_ready}, 64'd0);
        chk("rst async rd_valid", {62'd0, cl_rd_valid}, 64'd0);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        #1;
        check_all_zero("post-rst");
        clear_beats();

        @(negedge clock);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
